xbar_arb: RTL
=============

# xbar_arb

Two-input, two-output crossbar scheduler with registered outputs. Each input presents single-beat DW-bit words with a destination bit. Per cycle the block decides the crossbar setting (bar or cross) and grants inputs. When both inputs target the same output, it arbitrates round-robin and back-pressures the loser. It sits between the upstream compress lanes and the downstream lane consumers, so destination conflicts are resolved by stalling instead of being flagged as errors.

## Interface
- DW, 35, word width (32 data + 3 side bits)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- i_data0  in  DW  input 0 word
- i_valid0  in  1  input 0 word valid
- i_dest0  in  1  input 0 destination output index
- o_ready0  out  1  input 0 word accepted this cycle
- i_data1 / i_valid1 / i_dest1 / o_ready1: same for input 1
- o_data0  out  DW  output 0 word (registered)
- o_valid0  out  1  output 0 valid (registered)
- i_ready_out0  in  1  downstream 0 can take o_data0
- o_data1 / o_valid1 / i_ready_out1: same for output 1
- o_mode  out  1  crossbar setting of last transfer: 1 = cross, 0 = bar (registered)
- o_conflict_cnt  out  16  saturating count of conflict cycles (registered)

## Operation
- free_k = !o_valid_k || i_ready_outk, for k = 0, 1.
- A transfer on output register k happens when that register is free and it is loaded with a granted word.
- Conflict: i_valid0 && i_valid1 && (i_dest0 == i_dest1).
- No conflict:
  - Each valid input i is granted iff free_{dest_i}.
  - Grants are independent: one input may pass while the other stalls.
- Conflict:
  - The winner is input prio (1-bit pointer, reset 0).
  - The winner is granted iff free_{dest}.
  - The loser is never granted that cycle.
- Pointer update: when a conflict cycle grants the winner, prio <= ~winner. Otherwise prio holds, and non-conflict cycles never change it.
- o_ready_i = grant_i (combinational).
  - Depends on i_valid_i, i_dest_i, prio and output state.
  - Never asserted when i_valid_i = 0.
- Routing on grant of input i: o_data_{dest_i} <= i_data_i and o_valid_{dest_i} <= 1.
- For output k with no granted word: if i_ready_outk, then o_valid_k <= 0; otherwise o_valid_k and o_data_k hold.
- o_mode update:
  - Updated on any cycle with at least one grant.
  - mode = dest_i ^ i for granted input i.
  - If both inputs are granted, the two values agree by construction.
  - Holds otherwise.
- o_conflict_cnt increments by 1 on every conflict cycle, granted or not, and saturates at 16'hFFFF.
- Data beats are never duplicated or dropped. Order per input is preserved.

## Timing
- Latency: a word accepted at edge N (o_ready_i = 1 in the cycle before N) is visible on o_data/o_valid after edge N, i.e. 1 cycle.
- Throughput: 1 word per output per cycle when downstream is always ready.
- Full pass-through of both inputs with no conflict: 2 words/cycle.
- Back-pressure: if i_ready_outk = 0 while o_valid_k = 1, output k holds data and valid stable, and every input targeting k sees o_ready = 0.
- Reset values (rst = 1 at an edge):
  - o_valid0/1 = 0, o_data0/1 = 0, o_mode = 0, o_conflict_cnt = 0, prio = 0.
  - o_ready0/1 forced to 0 while rst = 1.
- Reset mid-operation: words held in output registers are discarded. No input is accepted during the reset cycle.
- Simultaneous load and drain on the same output (i_ready_outk = 1 and a grant to k): the new word loads and o_valid_k stays 1.

## Test plan
- Bar pass-through:
  - Stimulus: i_valid0/1 = 1, i_dest0 = 0, i_dest1 = 1, data 0x1/0x2, downstreams ready.
  - Response: both o_ready high. Next cycle o_data0 = 0x1, o_data1 = 0x2, o_mode = 0. Counter stays 0.
- Cross:
  - Stimulus: i_dest0 = 1, i_dest1 = 0, data 0xA/0xB.
  - Response: o_data1 = 0xA, o_data0 = 0xB, o_mode = 1.
- Conflict round-robin:
  - Stimulus: both valid with dest 0 for 4 cycles, fresh data each accepted beat, downstream 0 ready.
  - Response: grants alternate in0, in1, in0, in1. o_conflict_cnt = 4. o_valid1 stays 0.
- Back-pressure:
  - Stimulus: i_ready_out0 = 0 with o_valid0 = 1 holding 0x55; input 0 valid to dest 0.
  - Response: o_ready0 = 0 and o_data0 = 0x55 for the whole stall. prio is unchanged during a stalled conflict.
- Independent stall:
  - Stimulus: no conflict, output 1 stalled, output 0 ready.
  - Response: input to output 0 passes each cycle while the input to output 1 waits.
- Reset mid-stream plus saturation:
  - Stimulus: assert rst with both outputs valid.
  - Response: next cycle all outputs 0.
  - Stimulus: force 65540 conflict cycles.
  - Response: o_conflict_cnt = 0xFFFF.

Source files
------------

// File: rtl/xbar_arb.sv
// xbar_arb: a 2x2 crossbar scheduler with registered outputs.
// Each input offers one word per cycle with a destination bit. When both
// inputs want the same output, a round-robin pointer picks the winner and the
// loser stalls until a later cycle. Each output register loads when it is free,
// meaning it is empty or being drained this cycle.
module xbar_arb #(
   parameter int DW = 35
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i_data0,
   input  logic          i_valid0,
   input  logic          i_dest0,
   output logic          o_ready0,
   input  logic [DW-1:0] i_data1,
   input  logic          i_valid1,
   input  logic          i_dest1,
   output logic          o_ready1,
   output logic [DW-1:0] o_data0,
   output logic          o_valid0,
   input  logic          i_ready_out0,
   output logic [DW-1:0] o_data1,
   output logic          o_valid1,
   input  logic          i_ready_out1,
   output logic          o_mode,
   output logic [15:0]   o_conflict_cnt
);

   // Handshake: an input word moves when i_valid and o_ready are both high in
   // the same cycle. An output word moves when o_valid and i_ready_out are both
   // high. o_ready is a pure function of this cycle's inputs and the register
   // state, and it is never high without i_valid.

   // Round-robin pointer. It names the input that wins the next conflict.
   logic prio;

   logic free0;
   logic free1;
   logic conflict;
   logic grant0;
   logic grant1;
   logic load0;
   logic load1;
   logic [DW-1:0] next_data0;
   logic [DW-1:0] next_data1;

   // An output register can accept a word if it is empty or its word leaves now.
   always_comb begin
      free0 = !o_valid0 || i_ready_out0;
      free1 = !o_valid1 || i_ready_out1;
   end

   // Arbitration. Without a conflict each input needs only a free target.
   // With a conflict, only the pointed-to input may go.
   always_comb begin
      conflict = i_valid0 && i_valid1 && (i_dest0 == i_dest1);
      grant0   = 1'b0;
      grant1   = 1'b0;
      if (!rst) begin
         grant0 = i_valid0 && (i_dest0 ? free1 : free0) && (!conflict || !prio);
         grant1 = i_valid1 && (i_dest1 ? free1 : free0) && (!conflict ||  prio);
      end
   end

   assign o_ready0 = grant0;
   assign o_ready1 = grant1;

   // Steering. Grants never collide on one output, so each output has at most
   // one source.
   always_comb begin
      load0      = 1'b0;
      load1      = 1'b0;
      next_data0 = i_data1;
      next_data1 = i_data1;
      if (grant0 && !i_dest0) begin
         load0      = 1'b1;
         next_data0 = i_data0;
      end else if (grant1 && !i_dest1) begin
         load0      = 1'b1;
         next_data0 = i_data1;
      end
      if (grant0 && i_dest0) begin
         load1      = 1'b1;
         next_data1 = i_data0;
      end else if (grant1 && i_dest1) begin
         load1      = 1'b1;
         next_data1 = i_data1;
      end
   end

   // Output 0 register. It loads a granted word, empties when drained, and
   // otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data0  <= '0;
         o_valid0 <= 1'b0;
      end else if (load0) begin
         o_data0  <= next_data0;
         o_valid0 <= 1'b1;
      end else if (i_ready_out0) begin
         o_valid0 <= 1'b0;
      end
   end

   // Output 1 register. It behaves the same way as output 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data1  <= '0;
         o_valid1 <= 1'b0;
      end else if (load1) begin
         o_data1  <= next_data1;
         o_valid1 <= 1'b1;
      end else if (i_ready_out1) begin
         o_valid1 <= 1'b0;
      end
   end

   // Crossbar mode of the latest transfer. Cross means input i went to output
   // !i. Two simultaneous grants always imply the same mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_mode <= 1'b0;
      end else if (grant0) begin
         o_mode <= i_dest0;
      end else if (grant1) begin
         o_mode <= ~i_dest1;
      end
   end

   // Count conflict cycles, stalled or not, and stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_conflict_cnt <= 16'h0000;
      end else if (conflict && (o_conflict_cnt != 16'hFFFF)) begin
         o_conflict_cnt <= o_conflict_cnt + 16'h0001;
      end
   end

   // The pointer moves away from the winner only when the winner actually
   // transferred. A stalled conflict keeps the same winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= 1'b0;
      end else if (conflict && (grant0 || grant1)) begin
         prio <= ~prio;
      end
   end

endmodule
